pulse_decode: RTL
=================

PULSE_DECODE -- requirements
Module: pulse_decode

Interface
REQ-001 SHALL have parameter MIN_WIDTH, default 400, minimum accepted pulse high time in clk cycles.
REQ-002 SHALL have parameter MAX_WIDTH, default 480, maximum accepted pulse high time in clk cycles; MIN_WIDTH <= MAX_WIDTH < 8191.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pulse_in  input  1  incoming enable pulse, one pulse per switch activation.
REQ-006 SHALL have port pulse_valid  output  1  one-cycle strobe, in-window pulse accepted.
REQ-007 SHALL have port pulse_err  output  1  one-cycle strobe, pulse too short or too long.
REQ-008 SHALL have port level_out  output  1  reconstructed switch level, toggles on each accepted pulse.
REQ-009 SHALL have port width_out  output  13  high time of last accepted pulse, in cycles.
REQ-010 SHALL have port SM  output  2  current state, for debug.

Function
REQ-011 SHALL use sampled input s_in: pulse_in direct, or synchronised per REQ-030.
REQ-012 SHALL implement states WAIT_LOW=3, IDLE=0, MEASURE=1, TOO_LONG=2.
REQ-013 WAIT_LOW: s_in=0 -> IDLE; else stay; no strobes.
REQ-014 IDLE: s_in=1 -> MEASURE with count=1; else stay, count=0.
REQ-015 MEASURE, s_in=1: count increments by 1, saturating at 8191; on count reaching MAX_WIDTH+1 -> TOO_LONG and pulse_err=1 for that cycle.
REQ-016 MEASURE, s_in=0 with MIN_WIDTH <= count <= MAX_WIDTH: next cycle pulse_valid=1, level_out inverts, width_out=count, -> IDLE.
REQ-017 MEASURE, s_in=0 with count < MIN_WIDTH: next cycle pulse_err=1, level_out and width_out unchanged, -> IDLE.
REQ-018 TOO_LONG: s_in=0 -> IDLE; else stay; no further pulse_err for the same pulse.
REQ-019 Width SHALL equal number of cycles s_in sampled high; strobe latency 1 cycle after first low sample.
REQ-020 A single low sample SHALL terminate a pulse; a pulse starting the cycle after termination (1-cycle gap) SHALL be measured normally from IDLE.
REQ-021 pulse_valid and pulse_err SHALL never be asserted in the same cycle and SHALL each last exactly one cycle.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 rst=1 SHALL, at the next clk edge, force SM=WAIT_LOW, count=0, pulse_valid=0, pulse_err=0, level_out=0, width_out=0.
REQ-024 rst asserted mid-MEASURE SHALL discard the partial pulse with no strobe.
REQ-025 After rst, an input already high SHALL be ignored until it is sampled low, so a held switch does not produce a pulse.
REQ-026 Synchroniser flops, when present, SHALL reset to 0.

Configuration
REQ-030 With PULSE_DECODE_SYNC_EN defined, pulse_in SHALL pass through a 2-flop synchroniser before s_in, adding exactly 2 cycles to every strobe latency; measured widths are unchanged.
REQ-031 Without PULSE_DECODE_SYNC_EN, s_in SHALL be pulse_in sampled directly, with no added latency.

Verification
REQ-040 Reset release, 10 cycles low, pulse_in high 437 cycles -> single pulse_valid 1 cycle after the fall; level_out 0->1; width_out=437; pulse_err never set.
REQ-041 Pulse high 100 cycles -> single pulse_err 1 cycle after the fall; no pulse_valid; level_out, width_out unchanged.
REQ-042 Pulse high 600 cycles -> pulse_err exactly once, in the cycle the 481st high sample is counted; SM=2 until the fall; no pulse_valid.
REQ-043 pulse_in high at reset release for 50 cycles, low, then a 437-cycle pulse -> first high period ignored; one pulse_valid; level_out=1.
REQ-044 Pulses of 437 and 450 cycles separated by a 1-cycle low -> two pulse_valid strobes; level_out 0->1->0; width_out=450.
REQ-045 rst asserted at high cycle 200 of a pulse -> no strobes; all outputs 0; the remaining high time is ignored. Run REQ-040 with PULSE_DECODE_SYNC_EN defined -> strobe 3 cycles after the fall.

Source files
------------

// File: rtl/pulse_decode.sv
// Pulse-width decoder: measures pulse_in high time, accepts pulses within
// [MIN_WIDTH, MAX_WIDTH] and toggles level_out. Define PULSE_DECODE_SYNC_EN for a 2-flop input synchroniser.
module pulse_decode #(
  parameter int MIN_WIDTH = 400,
  parameter int MAX_WIDTH = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pulse_in,
  output logic        pulse_valid,
  output logic        pulse_err,
  output logic        level_out,
  output logic [12:0] width_out,
  output logic [1:0]  SM
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    TOO_LONG = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [12:0] MIN_W    = 13'(MIN_WIDTH);
  localparam logic [12:0] MAX_W    = 13'(MAX_WIDTH);
  localparam logic [12:0] OVER_W   = 13'(MAX_WIDTH + 1);
  localparam logic [12:0] CNT_SAT  = 13'h1fff;

  logic s_in;
  logic sync_ready;

`ifdef PULSE_DECODE_SYNC_EN
  logic       sync1_q, sync2_q;
  logic [1:0] fill_q;

  // fill_q keeps WAIT_LOW from trusting the reset value of the synchroniser,
  // so an input held high through reset is still ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'd0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
    end
  end

  assign s_in       = sync2_q;
  assign sync_ready = (fill_q == 2'd2);
`else
  assign s_in       = pulse_in;
  assign sync_ready = 1'b1;
`endif

  state_t      state_q, state_d;
  logic [12:0] count_q, count_d, count_inc;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        level_q, level_d;
  logic [12:0] width_q, width_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LOW;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      level_q <= 1'b0;
      width_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      level_q <= level_d;
      width_q <= width_d;
    end
  end

  assign count_inc = (count_q == CNT_SAT) ? count_q : count_q + 13'd1;

  // NOTE: every always_comb output gets a default first so no path
  // through the case leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    level_d = level_q;
    width_d = width_q;
    unique case (state_q)
      WAIT_LOW: begin
        count_d = '0;
        if (!s_in && sync_ready) state_d = IDLE;
      end
      IDLE: begin
        if (s_in) begin
          state_d = MEASURE;
          count_d = 13'd1;
        end else begin
          count_d = '0;
        end
      end
      MEASURE: begin
        if (s_in) begin
          count_d = count_inc;
          if (count_inc == OVER_W) begin
            state_d = TOO_LONG;
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
          count_d = '0;
          if (count_q >= MIN_W && count_q <= MAX_W) begin
            valid_d = 1'b1;
            level_d = ~level_q;
            width_d = count_q;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      TOO_LONG: begin
        if (!s_in) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  assign pulse_valid = valid_q;
  assign pulse_err   = err_q;
  assign level_out   = level_q;
  assign width_out   = width_q;
  assign SM          = state_q;

endmodule
